// File: rtl/iccm_arbiter.sv
// Two-port arbiter in front of a single-ported ICCM: instruction fetch vs. loader.
// Loader wins contention for up to MAX_BURST consecutive grants, then fetch gets one slot.
//
// owner_q   | meaning
// ----------+------------------------------------------------
// OWN_NONE  | no read issued last cycle (idle, write, reset)
// OWN_FETCH | last-cycle read belongs to fetch port
// OWN_LOAD  | last-cycle read belongs to loader port
module iccm_arbiter #(
    parameter int ADDR_WIDTH = 12,
    parameter int MAX_BURST  = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  fetch_en_i,

    input  logic                  f_req_i,
    input  logic [ADDR_WIDTH-1:0] f_addr_i,
    output logic                  f_gnt_o,
    output logic [31:0]           f_rdata_o,
    output logic                  f_rvalid_o,

    input  logic                  l_req_i,
    input  logic                  l_we_i,
    input  logic [ADDR_WIDTH-1:0] l_addr_i,
    input  logic [31:0]           l_wdata_i,
    input  logic [3:0]            l_wmask_i,
    output logic                  l_gnt_o,
    output logic [31:0]           l_rdata_o,
    output logic                  l_rvalid_o,

    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [31:0]           mem_wdata_o,
    output logic [3:0]            mem_wmask_o,
    input  logic [31:0]           mem_rdata_i,
    input  logic                  mem_rvalid_i
);

    localparam int              BW          = $clog2(MAX_BURST + 1);
    localparam logic [BW-1:0]   BURST_LIMIT = BW'(MAX_BURST);

    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_FETCH = 2'd1,
        OWN_LOAD  = 2'd2
    } owner_e;

    owner_e        owner_q;
    logic [BW-1:0] burst_cnt;
    logic          f_elig;
    logic          l_elig;
    logic          contend;
    logic          burst_full;

    always_comb begin
        f_elig     = f_req_i & fetch_en_i;
        l_elig     = l_req_i;
        contend    = f_elig & l_elig;
        burst_full = (burst_cnt == BURST_LIMIT);

        // Grants are held low for the whole reset so the memory sees no traffic.
        f_gnt_o    = rst_ni & f_elig & (~l_elig | burst_full);
        l_gnt_o    = rst_ni & l_elig & ~(contend & burst_full);

        mem_req_o   = f_gnt_o | l_gnt_o;
        mem_we_o    = l_gnt_o & l_we_i;
        mem_addr_o  = f_gnt_o ? f_addr_i : l_addr_i;
        mem_wdata_o = l_gnt_o ? l_wdata_i : '0;
        mem_wmask_o = l_gnt_o ? l_wmask_i : '0;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            burst_cnt <= '0;
            owner_q   <= OWN_NONE;
        end else begin
            // A loader grant under contention implies burst_cnt < limit, so no overflow.
            if (contend && l_gnt_o)
                burst_cnt <= burst_cnt + BW'(1);
            else
                burst_cnt <= '0;

            if (f_gnt_o)
                owner_q <= OWN_FETCH;
            else if (l_gnt_o && !l_we_i)
                owner_q <= OWN_LOAD;
            else
                owner_q <= OWN_NONE;
        end
    end

    assign f_rvalid_o = mem_rvalid_i & (owner_q == OWN_FETCH);
    assign l_rvalid_o = mem_rvalid_i & (owner_q == OWN_LOAD);
    assign f_rdata_o  = mem_rdata_i;
    assign l_rdata_o  = mem_rdata_i;

endmodule

// File: tb/tb_iccm_arbiter.sv
// Directed bench for iccm_arbiter with a one-cycle-latency memory model that returns
// {20'hC0DE0, addr} as read data; 'spur' injects unsolicited rvalids.
module tb_iccm_arbiter;

    localparam int AW = 12;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          fetch_en_i;
    logic          f_req_i;
    logic [AW-1:0] f_addr_i;
    logic          f_gnt_o;
    logic [31:0]   f_rdata_o;
    logic          f_rvalid_o;
    logic          l_req_i;
    logic          l_we_i;
    logic [AW-1:0] l_addr_i;
    logic [31:0]   l_wdata_i;
    logic [3:0]    l_wmask_i;
    logic          l_gnt_o;
    logic [31:0]   l_rdata_o;
    logic          l_rvalid_o;
    logic          mem_req_o;
    logic          mem_we_o;
    logic [AW-1:0] mem_addr_o;
    logic [31:0]   mem_wdata_o;
    logic [3:0]    mem_wmask_o;
    logic [31:0]   mem_rdata_i;
    logic          mem_rvalid_i;

    logic          mem_rv_q = 1'b0;
    logic [31:0]   mem_rd_q = '0;
    logic          spur;

    int n_run  = 0;
    int n_fail = 0;

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) begin
        mem_rv_q <= mem_req_o & ~mem_we_o;
        mem_rd_q <= {20'hC0DE0, mem_addr_o};
    end

    assign mem_rvalid_i = mem_rv_q | spur;
    assign mem_rdata_i  = mem_rd_q;

    iccm_arbiter #(.ADDR_WIDTH(AW), .MAX_BURST(4)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .fetch_en_i  (fetch_en_i),
        .f_req_i     (f_req_i),
        .f_addr_i    (f_addr_i),
        .f_gnt_o     (f_gnt_o),
        .f_rdata_o   (f_rdata_o),
        .f_rvalid_o  (f_rvalid_o),
        .l_req_i     (l_req_i),
        .l_we_i      (l_we_i),
        .l_addr_i    (l_addr_i),
        .l_wdata_i   (l_wdata_i),
        .l_wmask_i   (l_wmask_i),
        .l_gnt_o     (l_gnt_o),
        .l_rdata_o   (l_rdata_o),
        .l_rvalid_o  (l_rvalid_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_wmask_o (mem_wmask_o),
        .mem_rdata_i (mem_rdata_i),
        .mem_rvalid_i(mem_rvalid_i)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
    task automatic next();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk_gnt(input string tag, input bit f_exp);
        #1;
        chk({tag, "_f_gnt"}, 32'(f_gnt_o), 32'(f_exp));
        chk({tag, "_l_gnt"}, 32'(l_gnt_o), 32'(!f_exp));
    endtask

    logic [9:0] pat10;
    logic [4:0] pat5;

    initial begin
        rst_ni = 1'b0; spur = 1'b0;
        fetch_en_i = 1'b1; f_req_i = 1'b1; f_addr_i = '0;
        l_req_i = 1'b1; l_we_i = 1'b0; l_addr_i = '0; l_wdata_i = '0; l_wmask_i = '0;

        // Grants and memory request held low throughout reset
        repeat (2) next();
        #1;
        chk("rst_f_gnt", 32'(f_gnt_o), 0);
        chk("rst_l_gnt", 32'(l_gnt_o), 0);
        chk("rst_mem_req", 32'(mem_req_o), 0);
        chk("rst_mem_we", 32'(mem_we_o), 0);

        next();
        rst_ni = 1'b1; f_req_i = 1'b0; l_req_i = 1'b0;
        #1;
        chk("post_rst_f_rvalid", 32'(f_rvalid_o), 0);
        chk("post_rst_l_rvalid", 32'(l_rvalid_o), 0);

        // Loader write while fetch disabled
        next();
        fetch_en_i = 1'b0; f_req_i = 1'b1; f_addr_i = 12'h100;
        l_req_i = 1'b1; l_we_i = 1'b1; l_addr_i = 12'h010;
        l_wdata_i = 32'hDEADBEEF; l_wmask_i = 4'hF;
        #1;
        chk("wr_l_gnt", 32'(l_gnt_o), 1);
        chk("wr_f_gnt", 32'(f_gnt_o), 0);
        chk("wr_mem_req", 32'(mem_req_o), 1);
        chk("wr_mem_we", 32'(mem_we_o), 1);
        chk("wr_mem_addr", 32'(mem_addr_o), 32'h010);
        chk("wr_mem_wdata", mem_wdata_o, 32'hDEADBEEF);
        chk("wr_mem_wmask", 32'(mem_wmask_o), 32'hF);

        next();
        f_req_i = 1'b0; l_req_i = 1'b0; l_we_i = 1'b0; spur = 1'b1;
        #1;
        chk("wr_no_l_rvalid", 32'(l_rvalid_o), 0);
        chk("wr_no_f_rvalid", 32'(f_rvalid_o), 0);

        // Continuous contention: L,L,L,L,F repeating (bit set = fetch)
        next();
        spur = 1'b0; fetch_en_i = 1'b1;
        f_req_i = 1'b1; f_addr_i = 12'h100; l_req_i = 1'b1; l_addr_i = 12'h200;
        pat10 = 10'b10000_10000;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) next();
            chk_gnt($sformatf("burst%0d", i), pat10[i]);
            if (i > 0) begin
                chk($sformatf("burst%0d_f_rvalid", i), 32'(f_rvalid_o), 32'(pat10[i-1]));
                chk($sformatf("burst%0d_l_rvalid", i), 32'(l_rvalid_o), 32'(!pat10[i-1]));
            end
            if (i == 1) chk("burst_l_rdata", l_rdata_o, 32'hC0DE0200);
        end
        next();
        f_req_i = 1'b0; l_req_i = 1'b0;
        #1;
        chk("burst_end_f_rvalid", 32'(f_rvalid_o), 1);
        chk("burst_end_l_rvalid", 32'(l_rvalid_o), 0);
        chk("burst_end_f_rdata", f_rdata_o, 32'hC0DE0100);

        // Loader read then fetch read on consecutive cycles
        next();
        l_req_i = 1'b1; l_we_i = 1'b0; l_addr_i = 12'h004;
        chk_gnt("b2b_l", 1'b0);
        next();
        l_req_i = 1'b0; l_wdata_i = 32'h12345678; l_wmask_i = 4'hF;
        f_req_i = 1'b1; f_addr_i = 12'h008;
        chk_gnt("b2b_f", 1'b1);
        chk("b2b_l_rvalid", 32'(l_rvalid_o), 1);
        chk("b2b_f_rvalid_early", 32'(f_rvalid_o), 0);
        chk("b2b_l_rdata", l_rdata_o, 32'hC0DE0004);
        chk("b2b_mem_addr", 32'(mem_addr_o), 32'h008);
        chk("b2b_mem_we", 32'(mem_we_o), 0);
        chk("b2b_mem_wmask", 32'(mem_wmask_o), 0);
        chk("b2b_mem_wdata", mem_wdata_o, 0);
        next();
        f_req_i = 1'b0;
        #1;
        chk("b2b_f_rvalid", 32'(f_rvalid_o), 1);
        chk("b2b_l_rvalid_late", 32'(l_rvalid_o), 0);
        chk("b2b_f_rdata", f_rdata_o, 32'hC0DE0008);

        // fetch_en drops while fetch read outstanding
        next();
        f_req_i = 1'b1; f_addr_i = 12'h0AC;
        chk_gnt("fen_f", 1'b1);
        next();
        fetch_en_i = 1'b0;
        #1;
        chk("fen_f_gnt_off", 32'(f_gnt_o), 0);
        chk("fen_f_rvalid", 32'(f_rvalid_o), 1);
        chk("fen_f_rdata", f_rdata_o, 32'hC0DE00AC);

        // Reset with a fetch read in flight
        next();
        fetch_en_i = 1'b1; f_req_i = 1'b1; f_addr_i = 12'h0F0;
        chk_gnt("rst2_f", 1'b1);
        next();
        rst_ni = 1'b0; l_req_i = 1'b1;
        #1;
        chk("rst2_f_gnt", 32'(f_gnt_o), 0);
        chk("rst2_l_gnt", 32'(l_gnt_o), 0);
        chk("rst2_mem_req", 32'(mem_req_o), 0);
        next();
        spur = 1'b1;
        #1;
        chk("rst2_f_rvalid", 32'(f_rvalid_o), 0);
        chk("rst2_l_rvalid", 32'(l_rvalid_o), 0);
        chk("rst2_f_gnt_held", 32'(f_gnt_o), 0);
        chk("rst2_l_gnt_held", 32'(l_gnt_o), 0);

        // Out of reset into contention: burst counter starts from zero
        next();
        rst_ni = 1'b1; spur = 1'b0; l_addr_i = 12'h300;
        pat5 = 5'b10000;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) next();
            chk_gnt($sformatf("rst2_burst%0d", i), pat5[i]);
        end

        // 3 contention cycles, fetch-only cycle, then a fresh burst of 4
        for (int i = 0; i < 3; i++) begin
            next();
            chk_gnt($sformatf("part%0d", i), 1'b0);
        end
        next();
        l_req_i = 1'b0;
        chk_gnt("part_f_only", 1'b1);
        next();
        l_req_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) next();
            chk_gnt($sformatf("restart%0d", i), pat5[i]);
        end

        // 3 contention cycles, loader-only cycle (no contention clears count), fresh burst
        for (int i = 0; i < 3; i++) begin
            next();
            chk_gnt($sformatf("lonly_pre%0d", i), 1'b0);
        end
        next();
        fetch_en_i = 1'b0;
        chk_gnt("lonly_gap", 1'b0);
        next();
        fetch_en_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) next();
            chk_gnt($sformatf("lonly_burst%0d", i), pat5[i]);
        end

        next();
        f_req_i = 1'b0; l_req_i = 1'b0;
        next();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
